// File: rtl/fake_source.sv
// rtl/fake_source.sv - test-only arithmetic-progression stream generator.
// Optional inter-beat gap counter: FAKE_SOURCE_GAP_EN.
module fake_source #(
    parameter int DATA_WIDTH    = 8,
    parameter int COUNTER_WIDTH = 8,
    parameter int GAP_CYCLES    = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [COUNTER_WIDTH-1:0] count,
    input  logic [DATA_WIDTH-1:0]    first_value,
    input  logic [DATA_WIDTH-1:0]    step,
    input  logic                     stall,
    output logic [DATA_WIDTH-1:0]    data,
    output logic                     valid,
    input  logic                     ready,
    output logic                     busy,
    output logic                     done,
    output logic [COUNTER_WIDTH-1:0] num_sent
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                   r_state;
    state_t                   w_state_next;
    logic [COUNTER_WIDTH-1:0] r_count_q;
    logic [COUNTER_WIDTH-1:0] r_num_sent;
    logic [DATA_WIDTH-1:0]    r_step_q;
    logic [DATA_WIDTH-1:0]    r_data;
    logic                     r_valid;

    logic                     w_xfer;
    logic                     w_start_ok;
    logic                     w_last;
    logic                     w_gap_ok;
    logic [COUNTER_WIDTH-1:0] w_num_sent_inc;

    assign w_xfer         = r_valid && ready;
    assign w_start_ok     = start && (r_state != S_RUN);
    assign w_num_sent_inc = r_num_sent + {{(COUNTER_WIDTH-1){1'b0}}, 1'b1};
    assign w_last         = (w_num_sent_inc == r_count_q);

`ifdef FAKE_SOURCE_GAP_EN
    localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    logic [GAP_W-1:0] r_gap;

    // The beat is offered on the edge where the counter reaches zero, so
    // accepted beats end up exactly GAP_CYCLES+1 cycles apart.
    assign w_gap_ok = (r_gap <= GAP_W'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_gap <= '0;
        end else if (w_start_ok) begin
            r_gap <= '0;
        end else if (r_state == S_RUN && w_xfer && !w_last && GAP_CYCLES > 0) begin
            r_gap <= GAP_W'(GAP_CYCLES);
        end else if (r_gap != '0) begin
            r_gap <= r_gap - GAP_W'(1);
        end
    end
`else
    assign w_gap_ok = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_state_next = (count == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (w_xfer && w_last) begin
                    w_state_next = S_DONE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Datapath: valid is only ever set from registered state and stall,
    // never from ready, and once high it is held until the transfer.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid    <= 1'b0;
            r_data     <= '0;
            r_num_sent <= '0;
            r_count_q  <= '0;
            r_step_q   <= '0;
        end else if (w_start_ok) begin
            r_count_q  <= count;
            r_step_q   <= step;
            r_data     <= first_value;
            r_num_sent <= '0;
            r_valid    <= (count != '0) && !stall;
        end else if (r_state == S_RUN) begin
            if (w_xfer) begin
                r_num_sent <= w_num_sent_inc;
                r_data     <= r_data + r_step_q;
                if (w_last) begin
                    r_valid <= 1'b0;
                end else begin
`ifdef FAKE_SOURCE_GAP_EN
                    r_valid <= (GAP_CYCLES == 0) ? !stall : 1'b0;
`else
                    r_valid <= !stall;
`endif
                end
            end else if (!r_valid && !stall && w_gap_ok) begin
                r_valid <= 1'b1;
            end
        end
    end

    always_comb begin
        busy     = (r_state == S_RUN);
        done     = (r_state == S_DONE);
        valid    = r_valid;
        data     = r_data;
        num_sent = r_num_sent;
    end

endmodule

// File: tb/tb_fake_source.sv
// tb/tb_fake_source.sv - directed bench for fake_source.
module tb_fake_source;

    logic       clk;
    logic       reset;
    logic       start;
    logic [7:0] count;
    logic [7:0] first_value;
    logic [7:0] step;
    logic       stall;
    logic [7:0] data;
    logic       valid;
    logic       ready;
    logic       busy;
    logic       done;
    logic [7:0] num_sent;

    int n_assert;
    int n_fail;

    fake_source #(
        .DATA_WIDTH   (8),
        .COUNTER_WIDTH(8),
        .GAP_CYCLES   (2)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .count      (count),
        .first_value(first_value),
        .step       (step),
        .stall      (stall),
        .data       (data),
        .valid      (valid),
        .ready      (ready),
        .busy       (busy),
        .done       (done),
        .num_sent   (num_sent)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_reset(input string tag);
        chk({tag, "_valid"}, 32'(valid), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_num"}, 32'(num_sent), 32'd0);
        chk({tag, "_data"}, 32'(data), 32'd0);
    endtask

    task automatic launch(input logic [7:0] c, input logic [7:0] fv, input logic [7:0] st);
        count       = c;
        first_value = fv;
        step        = st;
        start       = 1'b1;
        @(negedge clk);
        start       = 1'b0;
    endtask

    initial begin
        n_assert    = 0;
        n_fail      = 0;
        reset       = 1'b1;
        start       = 1'b0;
        count       = '0;
        first_value = '0;
        step        = '0;
        stall       = 1'b0;
        ready       = 1'b0;
        repeat (2) @(negedge clk);
        chk_idle_reset("reset");
        reset = 1'b0;

        // Back-to-back burst of 4 starting at 0x10
        ready = 1'b1;
        launch(8'd4, 8'h10, 8'd1);
        for (int i = 0; i < 4; i++) begin
            chk("b2b_valid", 32'(valid), 32'd1);
            chk("b2b_data", 32'(data), 32'h10 + 32'(i));
            chk("b2b_busy", 32'(busy), 32'd1);
            @(negedge clk);
        end
        chk("b2b_done", 32'(done), 32'd1);
        chk("b2b_valid_end", 32'(valid), 32'd0);
        chk("b2b_num", 32'(num_sent), 32'd4);
        chk("b2b_data_end", 32'(data), 32'h14);
        chk("b2b_busy_end", 32'(busy), 32'd0);
        @(negedge clk);
        chk("done_hold", 32'(done), 32'd1);
        chk("done_hold_data", 32'(data), 32'h14);

        // Ready toggling with data wrap
        ready = 1'b0;
        launch(8'd3, 8'hFE, 8'd1);
        for (int b = 0; b < 3; b++) begin
            ready = 1'b0;
            chk("tog_valid", 32'(valid), 32'd1);
            chk("tog_data", 32'(data), 32'((8'hFE + 8'(b)) & 8'hFF));
            @(negedge clk);
            chk("tog_hold_valid", 32'(valid), 32'd1);
            chk("tog_hold_data", 32'(data), 32'((8'hFE + 8'(b)) & 8'hFF));
            ready = 1'b1;
            @(negedge clk);
        end
        chk("tog_done", 32'(done), 32'd1);
        chk("tog_num", 32'(num_sent), 32'd3);
        chk("tog_data_end", 32'(data), 32'h01);

        // Stall at start, then stall raised while valid is high
        ready = 1'b0;
        stall = 1'b1;
        launch(8'd2, 8'h20, 8'd3);
        chk("stall_valid0", 32'(valid), 32'd0);
        chk("stall_busy", 32'(busy), 32'd1);
        @(negedge clk);
        chk("stall_valid1", 32'(valid), 32'd0);
        stall = 1'b0;
        @(negedge clk);
        chk("stall_rel_valid", 32'(valid), 32'd1);
        chk("stall_rel_data", 32'(data), 32'h20);
        stall = 1'b1;
        @(negedge clk);
        chk("stall_keep_valid", 32'(valid), 32'd1);
        chk("stall_keep_data", 32'(data), 32'h20);
        ready = 1'b1;
        @(negedge clk);
        chk("stall_after_xfer", 32'(valid), 32'd0);
        chk("stall_num1", 32'(num_sent), 32'd1);
        stall = 1'b0;
        @(negedge clk);
        chk("stall_b2_valid", 32'(valid), 32'd1);
        chk("stall_b2_data", 32'(data), 32'h23);
        @(negedge clk);
        chk("stall_done", 32'(done), 32'd1);
        chk("stall_num2", 32'(num_sent), 32'd2);
        chk("stall_data_end", 32'(data), 32'h26);

        // Zero-length burst
        launch(8'd0, 8'h55, 8'd1);
        chk("zero_done", 32'(done), 32'd1);
        chk("zero_busy", 32'(busy), 32'd0);
        chk("zero_valid", 32'(valid), 32'd0);
        chk("zero_num", 32'(num_sent), 32'd0);
        chk("zero_data", 32'(data), 32'h55);

        // Start during RUN is ignored
        ready = 1'b0;
        launch(8'd3, 8'h40, 8'd2);
        chk("ign_valid", 32'(valid), 32'd1);
        launch(8'd9, 8'h99, 8'd7);
        chk("ign_data", 32'(data), 32'h40);
        chk("ign_busy", 32'(busy), 32'd1);
        ready = 1'b1;
        @(negedge clk);
        chk("ign_data1", 32'(data), 32'h42);
        @(negedge clk);
        chk("ign_data2", 32'(data), 32'h44);
        @(negedge clk);
        chk("ign_done", 32'(done), 32'd1);
        chk("ign_num", 32'(num_sent), 32'd3);
        chk("ign_data_end", 32'(data), 32'h46);

        // Reset mid-burst, with start asserted alongside it
        launch(8'd5, 8'h00, 8'd1);
        repeat (2) @(negedge clk);
        chk("mid_num", 32'(num_sent), 32'd2);
        reset = 1'b1;
        start = 1'b1;
        @(negedge clk);
        chk_idle_reset("midrst");
        reset = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk("midrst_stay_idle", 32'(busy), 32'd0);

        // Fresh full burst after reset
        launch(8'd5, 8'h30, 8'h10);
        for (int i = 0; i < 5; i++) begin
            chk("fresh_valid", 32'(valid), 32'd1);
            chk("fresh_data", 32'(data), 32'h30 + 32'h10 * 32'(i));
            @(negedge clk);
        end
        chk("fresh_done", 32'(done), 32'd1);
        chk("fresh_num", 32'(num_sent), 32'd5);
        chk("fresh_data_end", 32'(data), 32'h80);

`ifdef FAKE_SOURCE_GAP_EN
        // Gapped beats: valid at T+1, T+4, T+7, done at T+8
        launch(8'd3, 8'h00, 8'd1);
        for (int c = 1; c <= 7; c++) begin
            chk("gap_valid", 32'(valid), (c == 1 || c == 4 || c == 7) ? 32'd1 : 32'd0);
            @(negedge clk);
        end
        chk("gap_done", 32'(done), 32'd1);
        chk("gap_num", 32'(num_sent), 32'd3);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/fake_source.md
Name: fake_source

Overview:
- Test-only stream generator that drives a valid/ready stream into a sink under test, e.g. the fake sink counter.
- On a start pulse it emits a programmed number of beats with arithmetic-progression data: first_value, first_value+step, and so on.
- Per-beat valid/ready handshake; an external stall throttles new beats.
- Reports busy, done, and beats sent, so a bench can compare them against the sink's count and last value.

Parameters:
- DATA_WIDTH, 8, width of data, first_value, step.
- COUNTER_WIDTH, 8, width of count and num_sent.
- GAP_CYCLES, 2, idle cycles inserted after each accepted beat (used only with FAKE_SOURCE_GAP_EN).

Ports:
- clk  input  1  the one clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin a burst; sampled in IDLE or DONE only.
- count  input  COUNTER_WIDTH  beats in the burst; latched at start.
- first_value  input  DATA_WIDTH  data of beat 0; latched at start.
- step  input  DATA_WIDTH  increment between beats; latched at start.
- stall  input  1  when high, no new beat is offered.
- data  output  DATA_WIDTH  stream payload.
- valid  output  1  stream valid (registered).
- ready  input  1  stream ready from the downstream consumer.
- busy  output  1  high in RUN.
- done  output  1  high in DONE.
- num_sent  output  COUNTER_WIDTH  beats accepted in the current/last burst.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, port named reset.
- Reset: at an edge with reset=1, state<=IDLE. Outputs: valid=0, data=0, busy=0, done=0, num_sent=0. Internal gap counter is cleared.
  - Reset mid-burst aborts it; valid is low from the next cycle.
  - Reset overrides start in the same cycle.
- Transfer: valid && ready at a rising edge.
- State machine, IDLE -> RUN -> DONE:
  - IDLE/DONE + start (cycle T):
    - count_q<=count, step_q<=step, data<=first_value, num_sent<=0.
    - If count==0: state<=DONE, valid stays 0, no beats.
    - Else state<=RUN and valid<=!stall(T). The first beat is therefore visible at T+1 if stall was low at T.
  - DONE with no start: hold. done stays 1; data and num_sent keep their final values.
  - RUN: start is ignored.
- RUN beat rules:
  - valid=0, gap counter 0, stall=0 at an edge: valid<=1.
  - valid=1: valid, data, and state are held until the transfer. Stall has no effect once valid is high, so valid never drops before acceptance.
  - On a transfer:
    - num_sent<=num_sent+1; data<=data+step_q, modulo 2^DATA_WIDTH, wrapping silently.
    - If num_sent+1==count_q: state<=DONE, valid<=0. data still advances once, so the final data value is first_value+count*step.
    - Otherwise valid<=!stall, giving back-to-back beats at one beat per cycle when ready=1 and stall=0.
- num_sent arithmetic: COUNTER_WIDTH bits. Maximum count is 2^COUNTER_WIDTH-1, so num_sent never wraps inside a burst.
- busy = (state==RUN); done = (state==DONE). Both are decoded from the state register, with no combinational path from inputs.
- ready is never used combinationally to drive valid or data.

Optional Feature:
- Macro: FAKE_SOURCE_GAP_EN.
- Defined: after every accepted beat except the last, the gap counter loads GAP_CYCLES. valid stays 0 while the counter is non-zero; the counter decrements each cycle. A new beat may be offered at the edge where the counter is 0 and stall=0. With stall=0 and ready=1, beats are therefore spaced GAP_CYCLES+1 cycles apart. GAP_CYCLES=0 behaves as undefined.
- Undefined: no gap counter is synthesized; back-to-back behaviour as above.

Test Plan:
- reset; count=4, first_value=8'h10, step=1, start, ready=1, stall=0 -> valid high 4 consecutive cycles with data 10,11,12,13; then done=1, num_sent=4, data=14, valid=0.
- count=3, first_value=8'hFE, step=1, ready toggling 1/0 -> data FE,FF,00, each held stable while ready=0; num_sent=3.
- stall=1 at start, count=2 -> valid stays 0 while stall=1. After stall drops, both beats are delivered. Raising stall with valid=1 does not drop valid.
- count=0 start -> DONE next cycle, valid never asserted, num_sent=0. start during RUN -> ignored, burst unchanged.
- reset asserted mid-burst after 2 of 5 beats -> next cycle valid=0, busy=0, done=0, num_sent=0. A new start then runs a full fresh burst.
- With FAKE_SOURCE_GAP_EN, GAP_CYCLES=2, count=3, ready=1 -> valid pulses at cycles T+1, T+4, T+7; done at T+8.
